codix_dbus_responder: RTL and testbench

//  Responder (slave) end of the codix_risc data-bus protocol. The core's dbus port is the initiator.

---
 rtl/codix_dbus_pkg.sv | 53 +++++
 rtl/codix_sp_ram.sv | 33 +++
 rtl/codix_dbus_responder.sv | 130 +++++++++++++
 tb/tb_codix_dbus_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/codix_dbus_pkg.sv
// rtl/codix_dbus_pkg.sv - shared types and lane helpers for the codix data-bus responder
package codix_dbus_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } reqcmd_e;

  typedef enum logic [1:0] {
    SI_BYTE = 2'd0,
    SI_HALF = 2'd1,
    SI_WORD = 2'd2
  } si_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RDATA = 2'd2,
    S_WDATA = 2'd3
  } state_e;

  // Byte enables for an access; all-zero marks a misaligned or reserved-size access.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SI_BYTE: be = 4'b0001 << a;
      SI_HALF: be = a[0] ? 4'b0000 : (a[1] ? 4'b1100 : 4'b0011);
      SI_WORD: be = (a == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Move the addressed lane down to bit 0 and extend; bad accesses read as zero.
  function automatic logic [31:0] rd_extract(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] a, input logic sc);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {a, 3'b000};
    res = 32'd0;
    if (be_gen(size, a) != 4'b0000) begin
      case (size)
        SI_BYTE: res = {{24{sc & sh[7]}}, sh[7:0]};
        SI_HALF: res = {{16{sc & sh[15]}}, sh[15:0]};
        default: res = word;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/codix_sp_ram.sv
// rtl/codix_sp_ram.sv - 1R/1W synchronous word SRAM with per-byte write enables
module codix_sp_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] r_rdata;

  // Byte-masked write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/codix_dbus_responder.sv
// rtl/codix_dbus_responder.sv - responder end of the codix dbus: wait states, lane logic, SRAM
module codix_dbus_responder
  import codix_dbus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int LAT        = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] dbus_A0,
  input  logic [1:0]        dbus_SI0,
  input  logic              dbus_SC0,
  input  logic [1:0]        dbus_REQCMD0,
  output logic              dbus_REQRESP0,
  output logic [DATA_W-1:0] dbus_Q0,
  output logic              dbus_IFRESP0,
  input  logic              dbus_IFCMD0,
  input  logic [DATA_W-1:0] dbus_D0,
  input  logic              dbus_OFCMD0,
  output logic              dbus_OFRESP0,
  output logic              dbus_ERR0
);

  localparam int AW = DEPTH_LOG2 + 2;

  state_e                r_state, w_next;
  logic [3:0]            r_cnt;
  logic [AW-1:0]         r_addr;
  logic [1:0]            r_size;
  logic                  r_sc, r_wr;
  logic [31:0]           r_q;
  logic                  w_req_rd, w_req_wr, w_accept, w_rd_done, w_wr_done, w_bad;
  logic [3:0]            w_be;
  logic [31:0]           w_rdata, w_rd_val, w_wdata;
  logic [DEPTH_LOG2-1:0] w_raddr;
  logic                  w_unused;

  // Address bits above the SRAM range alias by design.
  assign w_unused  = ^dbus_A0[ADDR_W-1:AW];

  assign w_req_rd  = (dbus_REQCMD0 == CMD_READ);
  assign w_req_wr  = (dbus_REQCMD0 == CMD_WRITE);
  assign w_accept  = RST && (r_state == S_IDLE) && (w_req_rd || w_req_wr);
  assign w_rd_done = (r_state == S_RDATA) && dbus_IFCMD0;
  assign w_wr_done = (r_state == S_WDATA) && dbus_OFCMD0;
  assign w_be      = be_gen(r_size, r_addr[1:0]);
  assign w_bad     = (w_be == 4'b0000);
  assign w_rd_val  = rd_extract(w_rdata, r_size, r_addr[1:0], r_sc);
  assign w_wdata   = dbus_D0 << {r_addr[1:0], 3'b000};
  // In IDLE the SRAM is addressed straight from the bus so LAT=0 still has data on RDATA entry.
  assign w_raddr   = (r_state == S_IDLE) ? dbus_A0[AW-1:2] : r_addr[AW-1:2];
  assign dbus_Q0   = (r_state == S_RDATA) ? w_rd_val : r_q;

  codix_sp_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (CLK),
    .i_we    (w_wr_done && !w_bad),
    .i_be    (w_be),
    .i_waddr (r_addr[AW-1:2]),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Capture the request on acceptance and count down the wait states.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt  <= 4'd0;
      r_addr <= '0;
      r_size <= 2'd0;
      r_sc   <= 1'b0;
      r_wr   <= 1'b0;
    end else if (w_accept) begin
      r_addr <= dbus_A0[AW-1:0];
      r_size <= dbus_SI0;
      r_sc   <= dbus_SC0;
      r_wr   <= w_req_wr;
      r_cnt  <= (LAT == 0) ? 4'd0 : 4'(LAT - 1);
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Hold the last delivered read data on Q0 once the access has completed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           r_q <= 32'd0;
    else if (w_rd_done) r_q <= w_rd_val;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next        = r_state;
    dbus_REQRESP0 = 1'b0;
    dbus_IFRESP0  = 1'b0;
    dbus_OFRESP0  = 1'b0;
    dbus_ERR0     = 1'b0;
    case (r_state)
      S_IDLE: begin
        dbus_REQRESP0 = RST;
        if (w_accept) w_next = (LAT == 0) ? (w_req_wr ? S_WDATA : S_RDATA) : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = r_wr ? S_WDATA : S_RDATA;
      end
      S_RDATA: begin
        dbus_IFRESP0 = 1'b1;
        if (dbus_IFCMD0) begin
          w_next    = S_IDLE;
          dbus_ERR0 = w_bad;
        end
      end
      S_WDATA: begin
        dbus_OFRESP0 = dbus_OFCMD0;
        if (dbus_OFCMD0) begin
          w_next    = S_IDLE;
          dbus_ERR0 = w_bad;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_codix_dbus_responder.sv
// tb/tb_codix_dbus_responder.sv - directed and randomized bench against a byte-addressed memory model
module tb_codix_dbus_responder;

  localparam int LAT = 2;
  localparam int DL  = 12;
  localparam logic [31:0] WRAP = 32'd4 << DL;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] dbus_A0 = '0;
  logic [1:0]  dbus_SI0 = '0;
  logic        dbus_SC0 = 1'b0;
  logic [1:0]  dbus_REQCMD0 = '0;
  logic        dbus_REQRESP0;
  logic [31:0] dbus_Q0;
  logic        dbus_IFRESP0;
  logic        dbus_IFCMD0 = 1'b0;
  logic [31:0] dbus_D0 = '0;
  logic        dbus_OFCMD0 = 1'b0;
  logic        dbus_OFRESP0;
  logic        dbus_ERR0;

  codix_dbus_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(DL), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .dbus_A0(dbus_A0), .dbus_SI0(dbus_SI0), .dbus_SC0(dbus_SC0),
    .dbus_REQCMD0(dbus_REQCMD0), .dbus_REQRESP0(dbus_REQRESP0), .dbus_Q0(dbus_Q0),
    .dbus_IFRESP0(dbus_IFRESP0), .dbus_IFCMD0(dbus_IFCMD0), .dbus_D0(dbus_D0),
    .dbus_OFCMD0(dbus_OFCMD0), .dbus_OFRESP0(dbus_OFRESP0), .dbus_ERR0(dbus_ERR0)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] mb [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input logic [31:0] a, input logic [1:0] si);
    return (si == 2'd3) || (si == 2'd1 && a[0]) || (si == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic int bidx(input logic [31:0] a);
    return int'(a % WRAP);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] si, input logic [31:0] d);
    if (!misal(a, si))
      for (int k = 0; k < (1 << si); k++) mb[bidx(a + k)] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] si, input logic sc);
    logic [31:0] v;
    int n;
    if (misal(a, si)) return 32'd0;
    n = 1 << si;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (!mb.exists(bidx(a + k))) return 'x;
      v[8*k +: 8] = mb[bidx(a + k)];
    end
    if (sc && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic do_read(input logic [31:0] a, input logic [1:0] si, input logic sc, input int hold,
                         output logic [31:0] q, output logic err, output int lat, output logic stable);
    logic [31:0] q0;
    int n;
    @(negedge CLK);
    dbus_A0 = a; dbus_SI0 = si; dbus_SC0 = sc; dbus_REQCMD0 = 2'd1;
    #1;
    n = 0;
    while (!dbus_REQRESP0 && n < 50) begin @(negedge CLK); #1; n++; end
    @(negedge CLK);
    dbus_REQCMD0 = 2'd0; dbus_A0 = $urandom; dbus_SI0 = 2'($urandom); dbus_SC0 = 1'($urandom);
    #1;
    lat = 1;
    while (!dbus_IFRESP0 && lat < 50) begin @(negedge CLK); #1; lat++; end
    q0 = dbus_Q0;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK); #1;
      if (!dbus_IFRESP0 || dbus_Q0 !== q0 || dbus_ERR0) stable = 1'b0;
    end
    dbus_IFCMD0 = 1'b1;
    #1;
    q = dbus_Q0; err = dbus_ERR0;
    @(negedge CLK);
    dbus_IFCMD0 = 1'b0;
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] si, input logic [31:0] d,
                          output logic err, output int lat);
    int n;
    @(negedge CLK);
    dbus_A0 = a; dbus_SI0 = si; dbus_REQCMD0 = 2'd2;
    #1;
    n = 0;
    while (!dbus_REQRESP0 && n < 50) begin @(negedge CLK); #1; n++; end
    @(negedge CLK);
    dbus_REQCMD0 = 2'd0; dbus_A0 = $urandom; dbus_SI0 = 2'($urandom); dbus_D0 = d; dbus_OFCMD0 = 1'b1;
    #1;
    lat = 1;
    while (!dbus_OFRESP0 && lat < 50) begin @(negedge CLK); #1; lat++; end
    err = dbus_ERR0;
    @(negedge CLK);
    dbus_OFCMD0 = 1'b0; dbus_D0 = $urandom;
    #1;
  endtask

  initial begin
    logic [31:0] q, a, d;
    logic        err, stable, sc;
    logic [1:0]  si;
    int          lat, hold;

    // 1. Reset with a READ request pending.
    RST = 1'b0; dbus_REQCMD0 = 2'd1; dbus_A0 = 32'h100; dbus_IFCMD0 = 1'b1; dbus_OFCMD0 = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_reqresp", dbus_REQRESP0, 0);
    check("rst_ifresp", dbus_IFRESP0, 0);
    check("rst_ofresp", dbus_OFRESP0, 0);
    check("rst_err", dbus_ERR0, 0);
    check("rst_q", dbus_Q0, 0);
    @(negedge CLK);
    RST = 1'b1; dbus_IFCMD0 = 1'b0; dbus_OFCMD0 = 1'b0;
    #1;
    check("post_rst_reqresp", dbus_REQRESP0, 1);
    dbus_REQCMD0 = 2'd0;

    // Reserved command is ignored.
    @(negedge CLK); dbus_REQCMD0 = 2'd3;
    @(negedge CLK); dbus_REQCMD0 = 2'd0; #1;
    check("rsvd_cmd_idle", dbus_REQRESP0, 1);
    check("rsvd_cmd_ifresp", dbus_IFRESP0, 0);

    // 2. Word round trip.
    do_write(32'h100, 2'd2, 32'hDEADBEEF, err, lat); model_write(32'h100, 2'd2, 32'hDEADBEEF);
    check("wr_word_lat", 32'(lat), 32'(LAT + 1));
    check("wr_word_err", err, 0);
    do_read(32'h100, 2'd2, 1'b0, 0, q, err, lat, stable);
    check("rd_word_lat", 32'(lat), 32'(LAT + 1));
    check("rd_word_q", q, 32'hDEADBEEF);
    check("rd_word_err", err, 0);
    check("rd_done_ifresp", dbus_IFRESP0, 0);
    check("rd_q_hold", dbus_Q0, 32'hDEADBEEF);

    // 3. Sub-word access.
    do_write(32'h103, 2'd0, 32'hABCDEF80, err, lat); model_write(32'h103, 2'd0, 32'hABCDEF80);
    check("wr_byte_err", err, 0);
    do_read(32'h103, 2'd0, 1'b1, 0, q, err, lat, stable);
    check("rd_byte_sx", q, 32'hFFFFFF80);
    do_read(32'h103, 2'd0, 1'b0, 0, q, err, lat, stable);
    check("rd_byte_zx", q, 32'h00000080);
    do_read(32'h100, 2'd2, 1'b1, 0, q, err, lat, stable);
    check("rd_word_after_byte", q, model_read(32'h100, 2'd2, 1'b0));
    do_read(32'h102, 2'd1, 1'b1, 0, q, err, lat, stable);
    check("rd_half_sx", q, model_read(32'h102, 2'd1, 1'b1));

    // 4. Backpressure, then immediate next request.
    do_read(32'h100, 2'd2, 1'b0, 5, q, err, lat, stable);
    check("bp_stable", stable, 1);
    check("bp_q", q, model_read(32'h100, 2'd2, 1'b0));
    check("bp_next_ack", dbus_REQRESP0, 1);
    check("bp_ifresp_low", dbus_IFRESP0, 0);
    do_read(32'h101, 2'd0, 1'b0, 0, q, err, lat, stable);
    check("bp_next_q", q, model_read(32'h101, 2'd0, 1'b0));

    // 5. Misaligned accesses.
    do_write(32'h101, 2'd1, 32'h00001234, err, lat); model_write(32'h101, 2'd1, 32'h00001234);
    check("mis_wr_err", err, 1);
    check("mis_wr_err_pulse", dbus_ERR0, 0);
    do_read(32'h100, 2'd2, 1'b0, 0, q, err, lat, stable);
    check("mis_wr_unchanged", q, model_read(32'h100, 2'd2, 1'b0));
    check("mis_wr_follow_err", err, 0);
    do_read(32'h102, 2'd2, 1'b0, 0, q, err, lat, stable);
    check("mis_rd_q", q, 0);
    check("mis_rd_err", err, 1);

    // 6. Address wrap and reset abort.
    do_read(32'h100 + WRAP, 2'd2, 1'b0, 0, q, err, lat, stable);
    check("wrap_q", q, model_read(32'h100, 2'd2, 1'b0));
    @(negedge CLK);
    dbus_A0 = 32'h100; dbus_SI0 = 2'd2; dbus_REQCMD0 = 2'd2;
    @(negedge CLK);
    dbus_REQCMD0 = 2'd0; dbus_D0 = 32'h55555555; dbus_OFCMD0 = 1'b1;
    #1;
    check("abort_in_wait", dbus_REQRESP0, 0);
    RST = 1'b0;
    #1;
    check("abort_rst_reqresp", dbus_REQRESP0, 0);
    check("abort_rst_ofresp", dbus_OFRESP0, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1; dbus_OFCMD0 = 1'b0;
    #1;
    check("abort_idle", dbus_REQRESP0, 1);
    do_read(32'h100, 2'd2, 1'b0, 0, q, err, lat, stable);
    check("abort_data_kept", q, model_read(32'h100, 2'd2, 1'b0));

    // Randomized traffic in a small window with aliasing.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_write(32'h200 + 32'(4 * i), 2'd2, d, err, lat);
      model_write(32'h200 + 32'(4 * i), 2'd2, d);
    end
    for (int i = 0; i < 60; i++) begin
      a    = 32'h200 + 32'($urandom_range(0, 63)) + WRAP * 32'($urandom_range(0, 3));
      si   = 2'($urandom_range(0, 3));
      sc   = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a, si, d, err, lat);
        model_write(a, si, d);
        check("rnd_wr_lat", 32'(lat), 32'(LAT + 1));
        check("rnd_wr_err", err, 32'(misal(a, si)));
      end else begin
        do_read(a, si, sc, hold, q, err, lat, stable);
        check("rnd_rd_q", q, model_read(a, si, sc));
        check("rnd_rd_err", err, 32'(misal(a, si)));
        check("rnd_rd_lat", 32'(lat), 32'(LAT + 1));
        check("rnd_rd_stable", stable, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
